tlb_ctrl: RTL and testbench
===========================

# tlb_ctrl

CP0-side sequencer for the MIPS TLB maintenance instructions TLBWI, TLBWR, TLBR and TLBP. It packs EntryHi/EntryLo0/EntryLo1 into the 86-bit TLB entry format and drives the TLB write port and probe port. It also reads entries back into CP0 format and maintains the Random register. It sits between the CP0 register file and the TLB array, on the opposite side of the TLB's write/probe interface.

## Interface
- TLB_ENTRIES, 16, number of TLB entries (power of two)
- TLB_WIDTH, $clog2(TLB_ENTRIES), entry index width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  instruction request
- op  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
- op_ready  out  1  high in IDLE; request accepted when op_valid&&op_ready
- op_done  out  1  one-cycle completion pulse
- entryhi_i, entrylo0_i, entrylo1_i, index_i, wired_i  in  32 each  CP0 register values
- wired_we  in  1  CP0 Wired being written this cycle
- tlb_config  out  86  packed entry to TLB
- tlb_config_index  out  TLB_WIDTH  write index
- tlb_we  out  1  TLB write strobe
- tlb_p  out  1  probe strobe (probe VPN2 taken from tlb_config[70:52])
- tlb_p_res_i  in  32  probe result: [31]=miss, [TLB_WIDTH-1:0]=match index
- tlb_rd_index  out  TLB_WIDTH  read index; TLB answers combinationally
- tlb_rd_entry  in  86  entry at tlb_rd_index
- index_we, entryhi_we, entrylo_we  out  1  CP0 writeback strobes
- index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o  out  32  CP0 writeback data

## Operation
- Entry layout:
  - [85:78] ASID
  - [77:72] zero
  - [71] G
  - [70:52] VPN2
  - [51:27] lo0 = {PFN[19:0], C[2:0], D, V}
  - [26:2] lo1, same format as lo0
  - [1:0] zero
- Pack: ASID=entryhi_i[7:0]; VPN2=entryhi_i[31:13]; PFN=entrylo[25:6]; C=[5:3]; D=[2]; V=[1]; G=entrylo0_i[0]&entrylo1_i[0].
- Unpack (TLBR):
  - entryhi_o={VPN2,5'b0,ASID}.
  - entrylo{0,1}_o={6'b0,PFN,C,D,V,G}.
- FSM IDLE -> EXEC -> WB -> IDLE. Inputs, op and the chosen index are registered on accept.
- EXEC:
  - TLBWI: tlb_we=1, index=index_i[TLB_WIDTH-1:0]; upper bits ignored.
  - TLBWR: tlb_we=1, index=Random value sampled at accept.
  - TLBP: tlb_p=1; result registered.
  - TLBR: tlb_rd_index=index_i; entry registered.
- WB:
  - op_done=1.
  - TLBP: index_we=1; index_o={miss,…0,idx}; on miss the index field is 0.
  - TLBR: entryhi_we=entrylo_we=1.
  - Writes: no CP0 writeback.
- Random:
  - Free-running down-counter, decrements every cycle.
  - At value ≤ wired (or 0) the next value is TLB_ENTRIES-1.
  - wired_we forces TLB_ENTRIES-1 next cycle.
  - random_o zero-extended.
- Reset:
  - State IDLE; random=TLB_ENTRIES-1; all strobes and op_done 0; data outputs 0.
  - Reset during EXEC/WB aborts; a write whose EXEC coincides with rst is suppressed.

## Timing
- Accept at cycle T. tlb_we/tlb_p at T+1. op_done and CP0 strobes at T+2. op_ready low T+1..T+2.
- Back-to-back: next accept at T+3.
- tlb_config and tlb_config_index are stable for the whole EXEC cycle.
- Probe after a write: TLBP accepted at T+3 sees the entry written at T+1.
- Simultaneous wired_we and TLBWR accept: the pre-reset Random value is used.

## Configuration
- TLB_CTRL_WIRED_EN defined: Random range is [wired_i[TLB_WIDTH-1:0], TLB_ENTRIES-1]. If wired ≥ TLB_ENTRIES-1, Random holds TLB_ENTRIES-1.
- Undefined: wired_i and wired_we are ignored; Random cycles over all entries [0, TLB_ENTRIES-1].

## Structure
- Shared package tlb_pkg:
  - TLB_ENTRIES/TLB_WIDTH constants.
  - op enum.
  - Packed struct for the 86-bit entry and its field offsets.
  - Pack/unpack functions.
- One sub-module: tlb_random (Random counter with wired bound).

## Test plan
- Reset with TLB_ENTRIES=16: random_o=15, op_ready=1, all strobes 0. Then with wired=4, Random counts 15→4 then wraps to 15.
- TLBWI with index=3, entryhi=0x12345_0AA, lo0=0x00001_03F, lo1=0x00002_03F: tlb_we at T+1, index 3, G=1, ASID=0xAA, VPN2=0x091A2.
- TLBP on the same VPN2 after that write: index_o=0x00000003 at T+2. TLBP on an unmapped VPN2: index_o=0x80000000.
- TLBR of index 3: entryhi_o=0x12344_0AA (low VPN bit 12 cleared), entrylo0_o=0x0000103F, entrylo1_o=0x0000203F.
- TLBWR accepted when Random=9: write lands at index 9. With wired_we in the same cycle, the write still uses 9 and Random becomes 15 next cycle.
- rst asserted in EXEC of a TLBWI: no tlb_we, no op_done; FSM is IDLE the next cycle.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB types: operation codes, the 86-bit entry layout and the CP0 <-> entry
// conversion helpers used by the maintenance sequencer.
package tlb_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_WIDTH   = $clog2(TLB_ENTRIES);

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_e;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_lo_t;

    typedef struct packed {
        logic [7:0]  asid;
        logic [5:0]  zero_hi;
        logic        g;
        logic [18:0] vpn2;
        tlb_lo_t     lo0;
        tlb_lo_t     lo1;
        logic [1:0]  zero_lo;
    } tlb_entry_t;

    localparam int ENTRY_WIDTH = 86;
    localparam int ASID_LSB    = 78;
    localparam int G_BIT       = 71;
    localparam int VPN2_LSB    = 52;
    localparam int LO0_LSB     = 27;
    localparam int LO1_LSB     = 2;

    // lo_field is EntryLo[25:1], which already matches {PFN, C, D, V}
    function automatic tlb_entry_t pack_entry(input logic [7:0]  asid,
                                              input logic [18:0] vpn2,
                                              input logic [24:0] lo0_field,
                                              input logic [24:0] lo1_field,
                                              input logic        g);
        tlb_entry_t e;
        e.asid    = asid;
        e.zero_hi = '0;
        e.g       = g;
        e.vpn2    = vpn2;
        e.lo0     = tlb_lo_t'(lo0_field);
        e.lo1     = tlb_lo_t'(lo1_field);
        e.zero_lo = '0;
        return e;
    endfunction

    function automatic logic [31:0] unpack_hi(input logic [18:0] vpn2, input logic [7:0] asid);
        return {vpn2, 5'b0, asid};
    endfunction

    function automatic logic [31:0] unpack_lo(input tlb_lo_t lo, input logic g);
        return {6'b0, lo, g};
    endfunction

endpackage

// File: rtl/tlb_random.sv
// Random register: free-running down-counter over the replaceable TLB slots.
// TLB_CTRL_WIRED_EN bounds the range from below by Wired; otherwise all entries cycle.
module tlb_random
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = tlb_pkg::TLB_ENTRIES,
    parameter int TLB_WIDTH   = $clog2(TLB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TLB_WIDTH-1:0] wired,
    input  logic                 wired_we,
    output logic [TLB_WIDTH-1:0] random
);

    localparam logic [TLB_WIDTH-1:0] TOP = TLB_WIDTH'(TLB_ENTRIES - 1);

    logic [TLB_WIDTH-1:0] random_reg;

`ifdef TLB_CTRL_WIRED_EN
    // Wired at or above the top slot pins Random to the top slot
    always_ff @(posedge clk) begin
        if (rst) begin
            random_reg <= TOP;
        end else if (wired_we || (random_reg <= wired) || (random_reg == '0)) begin
            random_reg <= TOP;
        end else begin
            random_reg <= random_reg - 1'b1;
        end
    end
`else
    logic unused_wired;
    assign unused_wired = ^{wired, wired_we};

    always_ff @(posedge clk) begin
        if (rst) begin
            random_reg <= TOP;
        end else if (random_reg == '0) begin
            random_reg <= TOP;
        end else begin
            random_reg <= random_reg - 1'b1;
        end
    end
`endif

    assign random = random_reg;

endmodule

// File: rtl/tlb_ctrl.sv
// CP0-side sequencer for TLBR/TLBWI/TLBWR/TLBP: IDLE -> EXEC -> WB.
// Optional TLB_CTRL_WIRED_EN restricts Random to the non-wired entries.
module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = tlb_pkg::TLB_ENTRIES,
    parameter int TLB_WIDTH   = $clog2(TLB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op,
    output logic                 op_ready,
    output logic                 op_done,
    input  logic [31:0]          entryhi_i,
    input  logic [31:0]          entrylo0_i,
    input  logic [31:0]          entrylo1_i,
    input  logic [31:0]          index_i,
    input  logic [31:0]          wired_i,
    input  logic                 wired_we,
    output logic [85:0]          tlb_config,
    output logic [TLB_WIDTH-1:0] tlb_config_index,
    output logic                 tlb_we,
    output logic                 tlb_p,
    input  logic [31:0]          tlb_p_res_i,
    output logic [TLB_WIDTH-1:0] tlb_rd_index,
    input  logic [85:0]          tlb_rd_entry,
    output logic                 index_we,
    output logic                 entryhi_we,
    output logic                 entrylo_we,
    output logic [31:0]          index_o,
    output logic [31:0]          entryhi_o,
    output logic [31:0]          entrylo0_o,
    output logic [31:0]          entrylo1_o,
    output logic [31:0]          random_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

    state_e               state_reg;
    tlb_op_e              op_reg;
    tlb_entry_t           cfg_reg;
    logic [TLB_WIDTH-1:0] idx_reg;
    logic                 we_reg;
    logic                 p_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 index_we_reg;
    logic                 entryhi_we_reg;
    logic                 entrylo_we_reg;
    logic [31:0]          index_o_reg;
    logic [31:0]          entryhi_o_reg;
    logic [31:0]          entrylo0_o_reg;
    logic [31:0]          entrylo1_o_reg;
    logic [TLB_WIDTH-1:0] random_val;

    tlb_entry_t           rd_entry;
    logic                 probe_miss;
    logic [TLB_WIDTH-1:0] probe_idx;

    tlb_random #(
        .TLB_ENTRIES(TLB_ENTRIES),
        .TLB_WIDTH  (TLB_WIDTH)
    ) u_random (
        .clk     (clk),
        .rst     (rst),
        .wired   (wired_i[TLB_WIDTH-1:0]),
        .wired_we(wired_we),
        .random  (random_val)
    );

    assign rd_entry   = tlb_entry_t'(tlb_rd_entry);
    assign probe_miss = tlb_p_res_i[31];
    assign probe_idx  = probe_miss ? '0 : tlb_p_res_i[TLB_WIDTH-1:0];

    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26],
                           index_i[31:TLB_WIDTH], wired_i[31:TLB_WIDTH],
                           tlb_p_res_i[30:TLB_WIDTH], rd_entry.zero_hi, rd_entry.zero_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_TLBR;
            cfg_reg        <= '0;
            idx_reg        <= '0;
            we_reg         <= 1'b0;
            p_reg          <= 1'b0;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            index_we_reg   <= 1'b0;
            entryhi_we_reg <= 1'b0;
            entrylo_we_reg <= 1'b0;
            index_o_reg    <= '0;
            entryhi_o_reg  <= '0;
            entrylo0_o_reg <= '0;
            entrylo1_o_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (op_valid) begin
                        state_reg <= S_EXEC;
                        ready_reg <= 1'b0;
                        op_reg    <= tlb_op_e'(op);
                        cfg_reg   <= pack_entry(entryhi_i[7:0], entryhi_i[31:13],
                                                entrylo0_i[25:1], entrylo1_i[25:1],
                                                entrylo0_i[0] & entrylo1_i[0]);
                        // Random is captured here so a same-cycle Wired write cannot move the target
                        idx_reg   <= (tlb_op_e'(op) == OP_TLBWR) ? random_val : index_i[TLB_WIDTH-1:0];
                        we_reg    <= (tlb_op_e'(op) == OP_TLBWI) || (tlb_op_e'(op) == OP_TLBWR);
                        p_reg     <= (tlb_op_e'(op) == OP_TLBP);
                    end
                end
                S_EXEC: begin
                    state_reg <= S_WB;
                    we_reg    <= 1'b0;
                    p_reg     <= 1'b0;
                    done_reg  <= 1'b1;
                    case (op_reg)
                        OP_TLBP: begin
                            index_we_reg <= 1'b1;
                            index_o_reg  <= {probe_miss, 31'(probe_idx)};
                        end
                        OP_TLBR: begin
                            entryhi_we_reg <= 1'b1;
                            entrylo_we_reg <= 1'b1;
                            entryhi_o_reg  <= unpack_hi(rd_entry.vpn2, rd_entry.asid);
                            entrylo0_o_reg <= unpack_lo(rd_entry.lo0, rd_entry.g);
                            entrylo1_o_reg <= unpack_lo(rd_entry.lo1, rd_entry.g);
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    state_reg      <= S_IDLE;
                    ready_reg      <= 1'b1;
                    done_reg       <= 1'b0;
                    index_we_reg   <= 1'b0;
                    entryhi_we_reg <= 1'b0;
                    entrylo_we_reg <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Gating with rst keeps a write from landing if reset arrives during EXEC
    assign tlb_we           = we_reg & ~rst;
    assign tlb_p            = p_reg;
    assign tlb_config       = cfg_reg;
    assign tlb_config_index = idx_reg;
    assign tlb_rd_index     = idx_reg;
    assign op_ready         = ready_reg;
    assign op_done          = done_reg;
    assign index_we         = index_we_reg;
    assign entryhi_we       = entryhi_we_reg;
    assign entrylo_we       = entrylo_we_reg;
    assign index_o          = index_o_reg;
    assign entryhi_o        = entryhi_o_reg;
    assign entrylo0_o       = entrylo0_o_reg;
    assign entrylo1_o       = entrylo1_o_reg;
    assign random_o         = 32'(random_val);

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl with a small behavioural TLB array on the write/probe/read ports.
module tb_tlb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_ready, op_done;
    logic [31:0] entryhi_i, entrylo0_i, entrylo1_i, index_i, wired_i;
    logic        wired_we;
    logic [85:0] tlb_config;
    logic [3:0]  tlb_config_index;
    logic        tlb_we, tlb_p;
    logic [31:0] tlb_p_res_i;
    logic [3:0]  tlb_rd_index;
    logic [85:0] tlb_rd_entry;
    logic        index_we, entryhi_we, entrylo_we;
    logic [31:0] index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o;

    int checks = 0;
    int failures = 0;

    logic [85:0] mem [16];
    logic        vld [16];

    tlb_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready), .op_done(op_done),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
        .index_i(index_i), .wired_i(wired_i), .wired_we(wired_we),
        .tlb_config(tlb_config), .tlb_config_index(tlb_config_index), .tlb_we(tlb_we),
        .tlb_p(tlb_p), .tlb_p_res_i(tlb_p_res_i), .tlb_rd_index(tlb_rd_index),
        .tlb_rd_entry(tlb_rd_entry), .index_we(index_we), .entryhi_we(entryhi_we),
        .entrylo_we(entrylo_we), .index_o(index_o), .entryhi_o(entryhi_o),
        .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o), .random_o(random_o)
    );

    always #5 clk = ~clk;

    // TLB array model: registered write, combinational read and VPN2 probe
    always @(posedge clk) begin
        if (tlb_we) begin
            mem[tlb_config_index] <= tlb_config;
            vld[tlb_config_index] <= 1'b1;
        end
    end

    assign tlb_rd_entry = mem[tlb_rd_index];

    always @* begin
        tlb_p_res_i = 32'h8000000F;
        for (int i = 0; i < 16; i++) begin
            if (vld[i] && mem[i][70:52] == tlb_config[70:52]) tlb_p_res_i = 32'(i);
        end
    end

    task automatic check(input string tag, input logic [85:0] got, input logic [85:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents a request in IDLE and returns at the negedge of its EXEC cycle
    task automatic start_op(input logic [1:0] o, input logic [31:0] idx);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        index_i  = idx;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    initial begin
        bit found;
        logic [31:0] exp_rand;

        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            vld[i] = 1'b0;
        end
        rst = 1'b1; op_valid = 1'b0; op = 2'd0; wired_we = 1'b0;
        entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0; index_i = '0; wired_i = 32'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_random", random_o, 32'd15);
        check("rst_ready", op_ready, 1'b1);
        check("rst_tlb_we", tlb_we, 1'b0);
        check("rst_tlb_p", tlb_p, 1'b0);
        check("rst_done", op_done, 1'b0);
        check("rst_wb_strobes", {index_we, entryhi_we, entrylo_we}, 3'b000);
        check("rst_data", {index_o, entryhi_o, entrylo0_o, entrylo1_o}, 128'd0);
        rst = 1'b0;

        for (int k = 0; k < 26; k++) begin
`ifdef TLB_CTRL_WIRED_EN
            exp_rand = 32'(15 - (k % 12));
`else
            exp_rand = 32'(15 - (k % 16));
`endif
            check($sformatf("random_seq%0d", k), random_o, exp_rand);
            @(negedge clk);
        end
        $display("random sequence checked over 26 cycles");

        // TLBWI index 3
        entryhi_i = 32'h123450AA; entrylo0_i = 32'h0000103F; entrylo1_i = 32'h0000203F;
        start_op(2'd1, 32'hFFFF_FFF3);
        check("wi_we", tlb_we, 1'b1);
        check("wi_index", tlb_config_index, 4'd3);
        check("wi_g", tlb_config[71], 1'b1);
        check("wi_asid", tlb_config[85:78], 8'hAA);
        check("wi_vpn2", tlb_config[70:52], 19'h091A2);
        check("wi_lo0", tlb_config[51:27], 25'h000081F);
        check("wi_lo1", tlb_config[26:2], 25'h000101F);
        check("wi_ready_exec", op_ready, 1'b0);
        @(negedge clk);
        check("wi_done", op_done, 1'b1);
        check("wi_we_off", tlb_we, 1'b0);
        check("wi_no_wb", {index_we, entryhi_we, entrylo_we}, 3'b000);
        check("wi_ready_wb", op_ready, 1'b0);
        @(negedge clk);
        check("wi_ready_t3", op_ready, 1'b1);
        check("wi_done_off", op_done, 1'b0);
        $display("TLBWI idx=3 entryhi=%08h", entryhi_i);

        // TLBP hit
        start_op(2'd3, 32'd0);
        check("p_hit_strobe", tlb_p, 1'b1);
        check("p_hit_no_we", tlb_we, 1'b0);
        @(negedge clk);
        check("p_hit_done", op_done, 1'b1);
        check("p_hit_index_we", index_we, 1'b1);
        check("p_hit_index", index_o, 32'h00000003);
        $display("TLBP hit index_o=%08h", index_o);

        // TLBP miss
        entryhi_i = 32'h400000AA;
        start_op(2'd3, 32'd0);
        @(negedge clk);
        check("p_miss_index_we", index_we, 1'b1);
        check("p_miss_index", index_o, 32'h80000000);
        $display("TLBP miss index_o=%08h", index_o);

        // TLBR index 3
        entryhi_i = 32'h0; entrylo0_i = 32'h0; entrylo1_i = 32'h0;
        start_op(2'd0, 32'd3);
        check("r_rd_index", tlb_rd_index, 4'd3);
        check("r_no_we", tlb_we, 1'b0);
        @(negedge clk);
        check("r_done", op_done, 1'b1);
        check("r_we", {index_we, entryhi_we, entrylo_we}, 3'b011);
        check("r_entryhi", entryhi_o, 32'h123440AA);
        check("r_entrylo0", entrylo0_o, 32'h0000103F);
        check("r_entrylo1", entrylo1_o, 32'h0000203F);
        $display("TLBR idx=3 entryhi_o=%08h lo0=%08h lo1=%08h", entryhi_o, entrylo0_o, entrylo1_o);

        // TLBWR accepted while Random=9, with a simultaneous Wired write
        entryhi_i = 32'h55556077; entrylo0_i = 32'h00000017; entrylo1_i = 32'h00000016;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (random_o == 32'd9) found = 1'b1;
        end
        check("wr_found_random9", found, 1'b1);
        op_valid = 1'b1; op = 2'd2; wired_we = 1'b1; index_i = 32'd1;
        @(negedge clk);
        op_valid = 1'b0; wired_we = 1'b0;
        check("wr_we", tlb_we, 1'b1);
        check("wr_index", tlb_config_index, 4'd9);
        check("wr_g", tlb_config[71], 1'b0);
`ifdef TLB_CTRL_WIRED_EN
        check("wr_random_after_wired_we", random_o, 32'd15);
`else
        check("wr_random_after_wired_we", random_o, 32'd8);
`endif
        @(negedge clk);
        check("wr_done", op_done, 1'b1);
        @(negedge clk);
        check("wr_landed", {vld[9], mem[9][70:52]}, {1'b1, 19'h2AAAB});
        $display("TLBWR idx=%0d random_o=%0d", 9, random_o);

        // Reset during EXEC of a TLBWI suppresses the write
        entryhi_i = 32'h0F0F0011;
        start_op(2'd1, 32'd5);
        check("abort_we_pre", tlb_we, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_we_gated", tlb_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", op_ready, 1'b1);
        check("abort_done", op_done, 1'b0);
        check("abort_random", random_o, 32'd15);
        @(negedge clk);
        check("abort_no_done", op_done, 1'b0);
        check("abort_not_written", vld[5], 1'b0);
        $display("TLBWI aborted by reset, idx=5 valid=%0b", vld[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
